// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped console transmitter:
// FSM encodings, default console address and character geometry.
package mmio_uart_tx_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [7:0] DEFAULT_TX_ADDR = 8'hFF;
    localparam logic [2:0] LAST_DATA_BIT   = 3'd7;
    localparam int unsigned CHAR_WIDTH     = 8;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO for the console transmitter. A push into a full FIFO is
// still accepted when a pop happens in the same cycle.
module mmio_uart_tx_sync_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == {CW{1'b0}});
    assign count     = count_q;
    assign head      = mem_q[rd_ptr_q];
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);

    // Next-state for storage, pointers and occupancy; pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Console output: stores to TX_ADDR are queued and serialised as 8N1 frames
// on a registered tx line.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 434,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  TX_ADDR    = DEFAULT_TX_ADDR
) (
    input  logic                          clock,
    input  logic                          clear,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_addr,
    input  logic [31:0]                   wr_data,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);

    logic [1:0]            state_q, state_d;
    logic [15:0]           baud_q, baud_d;
    logic [2:0]            bit_q, bit_d;
    logic [CHAR_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_q, tx_d;
    logic                  overflow_q, overflow_d;

    logic                  wr_hit_s;
    logic                  pop_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [CHAR_WIDTH-1:0] fifo_head_s;
    logic [$clog2(FIFO_DEPTH):0] fifo_count_s;
    logic                  unused_wr_data_s;

    // Only the low byte of a store is a character.
    assign unused_wr_data_s = ^wr_data[31:8];
    assign wr_hit_s         = wr_en & (wr_addr == TX_ADDR);

    mmio_uart_tx_sync_fifo #(
        .WIDTH (CHAR_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .clear     (clear),
        .push      (wr_hit_s),
        .push_data (wr_data[7:0]),
        .pop       (pop_s),
        .head      (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .count     (fifo_count_s)
    );

    // Framing FSM; the baud counter counts down to zero in every state.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = fifo_head_s;
                    baud_d  = BAUD_RELOAD;
                    bit_d   = 3'd0;
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end else begin
                    tx_d = 1'b1;
                end
            end
            ST_START: begin
                if (baud_q == 16'd0) begin
                    state_d = ST_DATA;
                    bit_d   = 3'd0;
                    baud_d  = BAUD_RELOAD;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q - 16'd1;
                    tx_d   = 1'b0;
                end
            end
            ST_DATA: begin
                if (baud_q == 16'd0) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_q == LAST_DATA_BIT) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[CHAR_WIDTH-1:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                    tx_d   = shift_q[0];
                end
            end
            ST_STOP: begin
                if (baud_q == 16'd0) begin
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        shift_d = fifo_head_s;
                        baud_d  = BAUD_RELOAD;
                        bit_d   = 3'd0;
                        state_d = ST_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                    tx_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = 16'd0;
                bit_d   = 3'd0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // A write is dropped only when the FIFO is full and nothing leaves it.
    always_comb begin
        if (wr_hit_s && fifo_full_s && !pop_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Transmitter state registers; reset abandons any frame and idles the line.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q    <= ST_IDLE;
            baud_q     <= 16'd0;
            bit_q      <= 3'd0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx         = tx_q;
    assign overflow   = overflow_q;
    assign fifo_count = fifo_count_s;
    assign tx_busy    = (state_q != ST_IDLE) | (fifo_count_s != '0);

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: three instances at CLK_DIV 4, 2 and 1.
module tb_mmio_uart_tx;

    logic        clock;
    logic        clear;
    logic        wr_en4, wr_en2, wr_en1;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        tx4, busy4, ovf4;
    logic        tx2, busy2, ovf2;
    logic        tx1, busy1, ovf1;
    logic [4:0]  cnt4, cnt2, cnt1;

    int vectors    = 0;
    int miscompares = 0;

    mmio_uart_tx #(.CLK_DIV(4), .FIFO_DEPTH(16), .TX_ADDR(8'hFF)) u_dut4 (
        .clock(clock), .clear(clear), .wr_en(wr_en4), .wr_addr(wr_addr),
        .wr_data(wr_data), .tx(tx4), .tx_busy(busy4), .fifo_count(cnt4),
        .overflow(ovf4)
    );
    mmio_uart_tx #(.CLK_DIV(2), .FIFO_DEPTH(16), .TX_ADDR(8'hFF)) u_dut2 (
        .clock(clock), .clear(clear), .wr_en(wr_en2), .wr_addr(wr_addr),
        .wr_data(wr_data), .tx(tx2), .tx_busy(busy2), .fifo_count(cnt2),
        .overflow(ovf2)
    );
    mmio_uart_tx #(.CLK_DIV(1), .FIFO_DEPTH(16), .TX_ADDR(8'hFF)) u_dut1 (
        .clock(clock), .clear(clear), .wr_en(wr_en1), .wr_addr(wr_addr),
        .wr_data(wr_data), .tx(tx1), .tx_busy(busy1), .fifo_count(cnt1),
        .overflow(ovf1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Frame position 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        else if (idx >= 9) return 1'b1;
        else return b[idx-1];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        clear = 1'b0;
        #12;
        vectors++;
        if ({tx4, tx2, tx1} !== 3'b111) begin
            miscompares++;
            $display("FAIL reset_tx got %b exp 111", {tx4, tx2, tx1});
        end
        vectors++;
        if ({busy4, busy2, busy1, ovf4, ovf2, ovf1} !== 6'b000000) begin
            miscompares++;
            $display("FAIL reset_flags got %b exp 000000", {busy4, busy2, busy1, ovf4, ovf2, ovf1});
        end
        vectors++;
        if ({cnt4, cnt2, cnt1} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_count got %0d/%0d/%0d exp 0", cnt4, cnt2, cnt1);
        end
        @(negedge clock);
        clear = 1'b1;
        tick();
        tick();
        vectors++;
        if (tx4 !== 1'b1 || busy4 !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle got tx=%b busy=%b exp tx=1 busy=0", tx4, busy4);
        end
    endtask

    task automatic test_single_byte();
        logic [9:0] exp_frame;
        exp_frame = 10'b1010000010;
        wr_addr = 8'hFF;
        wr_data = 32'h12345641;
        wr_en4  = 1'b1;
        tick();
        wr_en4  = 1'b0;
        vectors++;
        if (cnt4 !== 5'd1) begin
            miscompares++;
            $display("FAIL single_count_k got %0d exp 1", cnt4);
        end
        for (int c = 1; c <= 41; c++) begin
            tick();
            if (c == 1) begin
                vectors++;
                if (cnt4 !== 5'd0) begin
                    miscompares++;
                    $display("FAIL single_count_k1 got %0d exp 0", cnt4);
                end
            end
            if (c <= 40) begin
                vectors++;
                if (tx4 !== exp_frame[(c-1)/4]) begin
                    miscompares++;
                    $display("FAIL single_tx c=%0d got %b exp %b", c, tx4, exp_frame[(c-1)/4]);
                end
            end
            if (c == 40) begin
                vectors++;
                if (busy4 !== 1'b1) begin
                    miscompares++;
                    $display("FAIL single_busy_end got %b exp 1", busy4);
                end
            end
            if (c == 41) begin
                vectors++;
                if (busy4 !== 1'b0 || tx4 !== 1'b1) begin
                    miscompares++;
                    $display("FAIL single_idle got busy=%b tx=%b exp busy=0 tx=1", busy4, tx4);
                end
            end
        end
    endtask

    task automatic test_addr_filter();
        logic [7:0] addrs [3];
        logic       ens   [3];
        addrs[0] = 8'hFE; ens[0] = 1'b1;
        addrs[1] = 8'h00; ens[1] = 1'b1;
        addrs[2] = 8'hFF; ens[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_addr = addrs[i];
            wr_data = 32'h0000_0077;
            wr_en4  = ens[i];
            tick();
            wr_en4  = 1'b0;
            tick();
            vectors++;
            if (cnt4 !== 5'd0 || tx4 !== 1'b1 || busy4 !== 1'b0 || ovf4 !== 1'b0) begin
                miscompares++;
                $display("FAIL addr_filter i=%0d got cnt=%0d tx=%b busy=%b ovf=%b exp 0/1/0/0",
                         i, cnt4, tx4, busy4, ovf4);
            end
        end
    endtask

    task automatic test_burst_overflow();
        wr_addr = 8'hFF;
        for (int c = 0; c <= 681; c++) begin
            wr_en4  = (c <= 17);
            wr_data = 32'(c);
            tick();
            if (c >= 1 && c <= 680) begin
                int p;
                logic exp;
                p   = c - 1;
                exp = frame_bit(8'(p / 40), (p % 40) / 4);
                vectors++;
                if (tx4 !== exp) begin
                    miscompares++;
                    $display("FAIL burst_tx c=%0d got %b exp %b", c, tx4, exp);
                end
            end
            if (c == 0 || c == 1) begin
                vectors++;
                if (cnt4 !== 5'd1) begin
                    miscompares++;
                    $display("FAIL burst_count c=%0d got %0d exp 1", c, cnt4);
                end
            end
            if (c == 16) begin
                vectors++;
                if (cnt4 !== 5'd16 || ovf4 !== 1'b0) begin
                    miscompares++;
                    $display("FAIL burst_full got cnt=%0d ovf=%b exp 16/0", cnt4, ovf4);
                end
            end
            if (c == 17) begin
                vectors++;
                if (cnt4 !== 5'd16 || ovf4 !== 1'b1) begin
                    miscompares++;
                    $display("FAIL burst_drop got cnt=%0d ovf=%b exp 16/1", cnt4, ovf4);
                end
            end
            if (c == 680) begin
                vectors++;
                if (busy4 !== 1'b1) begin
                    miscompares++;
                    $display("FAIL burst_busy_end got %b exp 1", busy4);
                end
            end
            if (c == 681) begin
                vectors++;
                if (busy4 !== 1'b0 || tx4 !== 1'b1 || ovf4 !== 1'b1) begin
                    miscompares++;
                    $display("FAIL burst_idle got busy=%b tx=%b ovf=%b exp 0/1/1", busy4, tx4, ovf4);
                end
            end
        end
        wr_en4 = 1'b0;
    endtask

    task automatic test_back_to_back();
        wr_addr = 8'hFF;
        for (int c = 0; c <= 41; c++) begin
            wr_en2  = (c <= 1);
            wr_data = (c == 0) ? 32'h0000_0055 : 32'h0000_00AA;
            tick();
            if (c >= 1 && c <= 40) begin
                logic [7:0] b;
                logic       exp;
                b   = ((c - 1) / 20 == 0) ? 8'h55 : 8'hAA;
                exp = frame_bit(b, ((c - 1) % 20) / 2);
                vectors++;
                if (tx2 !== exp) begin
                    miscompares++;
                    $display("FAIL b2b_tx c=%0d got %b exp %b", c, tx2, exp);
                end
            end
            if (c == 40) begin
                vectors++;
                if (busy2 !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_busy_end got %b exp 1", busy2);
                end
            end
            if (c == 41) begin
                vectors++;
                if (busy2 !== 1'b0 || tx2 !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_idle got busy=%b tx=%b exp 0/1", busy2, tx2);
                end
            end
        end
        wr_en2 = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        wr_addr = 8'hFF;
        for (int c = 0; c <= 18; c++) begin
            wr_en4  = (c <= 2);
            wr_data = (c == 0) ? 32'h0F : ((c == 1) ? 32'h01 : 32'h02);
            tick();
            if (c >= 1) begin
                vectors++;
                if (tx4 !== frame_bit(8'h0F, (c - 1) / 4)) begin
                    miscompares++;
                    $display("FAIL midrst_tx c=%0d got %b exp %b", c, tx4, frame_bit(8'h0F, (c - 1) / 4));
                end
            end
        end
        wr_en4 = 1'b0;
        vectors++;
        if (cnt4 !== 5'd2 || busy4 !== 1'b1) begin
            miscompares++;
            $display("FAIL midrst_queued got cnt=%0d busy=%b exp 2/1", cnt4, busy4);
        end
        clear = 1'b0;
        #1;
        vectors++;
        if (tx4 !== 1'b1 || cnt4 !== 5'd0 || ovf4 !== 1'b0 || busy4 !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_async got tx=%b cnt=%0d ovf=%b busy=%b exp 1/0/0/0",
                     tx4, cnt4, ovf4, busy4);
        end
        @(negedge clock);
        clear = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (tx4 !== 1'b1 || busy4 !== 1'b0) begin
                miscompares++;
                $display("FAIL midrst_quiet i=%0d got tx=%b busy=%b exp 1/0", i, tx4, busy4);
            end
        end
        for (int c = 0; c <= 41; c++) begin
            wr_en4  = (c == 0);
            wr_data = 32'h0000_003C;
            tick();
            if (c >= 1 && c <= 40) begin
                vectors++;
                if (tx4 !== frame_bit(8'h3C, (c - 1) / 4)) begin
                    miscompares++;
                    $display("FAIL midrst_resume c=%0d got %b exp %b", c, tx4, frame_bit(8'h3C, (c - 1) / 4));
                end
            end
            if (c == 41) begin
                vectors++;
                if (busy4 !== 1'b0) begin
                    miscompares++;
                    $display("FAIL midrst_resume_idle got %b exp 0", busy4);
                end
            end
        end
        wr_en4 = 1'b0;
    endtask

    task automatic test_clkdiv1();
        logic [9:0] exp_frame;
        exp_frame = 10'b1110000110;
        wr_addr   = 8'hFF;
        for (int c = 0; c <= 11; c++) begin
            wr_en1  = (c == 0);
            wr_data = 32'h0000_00C3;
            tick();
            if (c == 0 || c == 1) begin
                vectors++;
                if (cnt1 !== ((c == 0) ? 5'd1 : 5'd0)) begin
                    miscompares++;
                    $display("FAIL div1_count c=%0d got %0d exp %0d", c, cnt1, (c == 0) ? 1 : 0);
                end
            end
            if (c >= 1 && c <= 10) begin
                vectors++;
                if (tx1 !== exp_frame[c-1]) begin
                    miscompares++;
                    $display("FAIL div1_tx c=%0d got %b exp %b", c, tx1, exp_frame[c-1]);
                end
            end
            if (c == 10) begin
                vectors++;
                if (busy1 !== 1'b1) begin
                    miscompares++;
                    $display("FAIL div1_busy_end got %b exp 1", busy1);
                end
            end
            if (c == 11) begin
                vectors++;
                if (busy1 !== 1'b0 || tx1 !== 1'b1) begin
                    miscompares++;
                    $display("FAIL div1_idle got busy=%b tx=%b exp 0/1", busy1, tx1);
                end
            end
        end
        wr_en1 = 1'b0;
    endtask

    initial begin
        clear   = 1'b0;
        wr_en4  = 1'b0;
        wr_en2  = 1'b0;
        wr_en1  = 1'b0;
        wr_addr = 8'h00;
        wr_data = 32'h0;
        test_reset();
        test_single_byte();
        test_addr_filter();
        test_burst_overflow();
        test_back_to_back();
        test_reset_mid_frame();
        test_clkdiv1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
